exc_ctrl: RTL

- Registered, parametrised exception/interrupt controller at the M stage of the MIPS32 pipeline.
- Samples M-stage fault flags and synchronised hardware interrupt lines, then prioritises them into one MIPS ExcCode.
- Issues a one-cycle commit pulse to CP0 carrying EPC/BD/BadVAddr, and drives a multi-cycle pipeline flush with the redirect PC.
- Handles ERET as a separate return path to EPC.

---
 rtl/exc_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// M-stage exception/interrupt controller: synchronises interrupt lines, prioritises
// faults into a MIPS ExcCode, pulses the CP0 commit and holds the pipeline flush.
module exc_ctrl #(
    parameter int          HW_INT_N     = 6,
    parameter int          SYNC_STAGES  = 2,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HW_INT_N-1:0] hw_int,
    input  logic                valid_m,
    input  logic                stall_m,
    input  logic [31:0]         pc_m,
    input  logic                bd_m,
    input  logic                adel_if_m,
    input  logic                ri_m,
    input  logic                sys_m,
    input  logic                brk_m,
    input  logic                ov_m,
    input  logic                adel_ld_m,
    input  logic                ades_m,
    input  logic                eret_m,
    input  logic [31:0]         addr_m,
    input  logic [7:0]          status_im,
    input  logic                status_exl,
    input  logic                status_ie,
    input  logic [1:0]          cause_ip_sw,
    input  logic [31:0]         cp0_epc,
    output logic [HW_INT_N-1:0] ip_hw,
    output logic                exc_commit,
    output logic [4:0]          exc_code,
    output logic [31:0]         exc_epc,
    output logic                exc_bd,
    output logic                bva_we,
    output logic [31:0]         exc_badvaddr,
    output logic                eret_commit,
    output logic                exc_flush,
    output logic [31:0]         exc_pc,
    output logic                busy
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} stateE;

    stateE             state, stateNext;
    logic [CNT_W-1:0]  flushCnt;
    logic [HW_INT_N-1:0] syncChain [SYNC_STAGES];

    logic [5:0]  ipHw6;
    logic        intPend;
    logic        faultAny;
    logic        riEff;
    logic        take;
    logic        isEret;
    logic        isAdr;
    logic [4:0]  codeNext;
    logic [31:0] badvNext;
    logic [31:0] epcNext;

    // Interrupt synchroniser: ip_hw is the last flop of each chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) syncChain[i] <= '0;
        end else begin
            syncChain[0] <= hw_int;
            for (int i = 1; i < SYNC_STAGES; i++) syncChain[i] <= syncChain[i-1];
        end
    end

    assign ip_hw = syncChain[SYNC_STAGES-1];

    always_comb begin
        ipHw6 = '0;
        ipHw6[HW_INT_N-1:0] = ip_hw;
    end

    assign intPend  = ((status_im & {ipHw6, cause_ip_sw}) != 8'd0) && status_ie && !status_exl;
    assign riEff    = ri_m & ~eret_m;
    assign faultAny = adel_if_m | riEff | sys_m | brk_m | ov_m | adel_ld_m | ades_m;
    assign take     = valid_m && !stall_m && (state == IDLE) && (intPend || faultAny || eret_m);
    assign epcNext  = bd_m ? (pc_m - 32'd4) : pc_m;
    assign busy     = (state == FLUSH);

    // First match wins; RI alongside ERET is folded into the return path
    always_comb begin
        isEret   = 1'b0;
        isAdr    = 1'b0;
        codeNext = 5'h00;
        badvNext = addr_m;
        if (intPend) begin
            codeNext = 5'h00;
        end else if (adel_if_m) begin
            codeNext = 5'h04;
            isAdr    = 1'b1;
            badvNext = pc_m;
        end else if (riEff) begin
            codeNext = 5'h0A;
        end else if (sys_m) begin
            codeNext = 5'h08;
        end else if (brk_m) begin
            codeNext = 5'h09;
        end else if (ov_m) begin
            codeNext = 5'h0C;
        end else if (adel_ld_m) begin
            codeNext = 5'h04;
            isAdr    = 1'b1;
        end else if (ades_m) begin
            codeNext = 5'h05;
            isAdr    = 1'b1;
        end else begin
            isEret   = eret_m;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (take) stateNext = FLUSH;
            FLUSH:   if (flushCnt == '0) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            flushCnt <= '0;
        end else begin
            state <= stateNext;
            if (take) flushCnt <= CNT_W'(FLUSH_CYCLES - 1);
            else if (state == FLUSH && flushCnt != '0) flushCnt <= flushCnt - 1'b1;
        end
    end

    // Commit registers: pulses clear every cycle, payload holds until the next commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_commit   <= 1'b0;
            exc_code     <= '0;
            exc_epc      <= '0;
            exc_bd       <= 1'b0;
            bva_we       <= 1'b0;
            exc_badvaddr <= '0;
            eret_commit  <= 1'b0;
            exc_flush    <= 1'b0;
            exc_pc       <= '0;
        end else begin
            exc_commit  <= 1'b0;
            eret_commit <= 1'b0;
            bva_we      <= 1'b0;
            if (take) begin
                exc_flush <= 1'b1;
                if (isEret) begin
                    eret_commit <= 1'b1;
                    exc_pc      <= cp0_epc;
                end else begin
                    exc_commit <= 1'b1;
                    exc_code   <= codeNext;
                    exc_epc    <= epcNext;
                    exc_bd     <= bd_m;
                    bva_we     <= isAdr;
                    exc_pc     <= EXC_VECTOR;
                    if (isAdr) exc_badvaddr <= badvNext;
                end
            end else if (state == FLUSH && flushCnt == '0) begin
                exc_flush <= 1'b0;
            end
        end
    end

endmodule
